// File: rtl/updn_sweep_pkg.sv
// Shared types for the up/down sweep sequencer; DWELL state exists only with SWEEP_DWELL_EN.
package updn_sweep_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int NSWP_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    UP,
    DOWN,
`ifdef SWEEP_DWELL_EN
    DWELL,
`endif
    FINISH
  } sweep_state_t;

endpackage

// File: rtl/updn_count_core.sv
// Registered up/down counter, load beats enable; one-cycle update latency, no backpressure.
// Wraps mod 2^WIDTH; the sequencer guarantees it never steps past its limits.
module updn_count_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dwbar,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = up_dwbar ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/updn_sweep_ctrl.sv
// Runs N triangular lo->hi->lo sweeps on updn_count_core; one sweep = 2*(hi-lo) cycles, start ignored while busy.
// Optional SWEEP_DWELL_EN adds DWELL hold cycles at each non-final turnaround.
module updn_sweep_ctrl
  import updn_sweep_pkg::*;
#(
`ifdef SWEEP_DWELL_EN
  parameter int DWELL  = 3,
`endif
  parameter int WIDTH  = WIDTH_DEF,
  parameter int NSWP_W = NSWP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [WIDTH-1:0]  lo_lim,
  input  logic [WIDTH-1:0]  hi_lim,
  input  logic [NSWP_W-1:0] n_sweeps,
  output logic [WIDTH-1:0]  count,
  output logic              up_dwbar,
  output logic              busy,
  output logic              done,
  output logic              err
);

  sweep_state_t      state_q, state_d;
  logic [WIDTH-1:0]  lo_q, lo_d, hi_q, hi_d;
  logic [NSWP_W-1:0] nsw_q, nsw_d, swp_q, swp_d, swp_inc;
  logic              up_q, up_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              core_en, core_load, core_dir;
  logic [WIDTH-1:0]  core_load_val;
`ifdef SWEEP_DWELL_EN
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  logic [DW_W-1:0]   dwell_q, dwell_d;
`endif

  assign swp_inc = swp_q + NSWP_W'(1);

  always_comb begin
    state_d       = state_q;
    lo_d          = lo_q;
    hi_d          = hi_q;
    nsw_d         = nsw_q;
    swp_d         = swp_q;
    up_d          = up_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_d         = err_q;
    core_en       = 1'b0;
    core_load     = 1'b0;
    core_dir      = 1'b1;
    core_load_val = lo_lim;
`ifdef SWEEP_DWELL_EN
    dwell_d       = dwell_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (lo_lim < hi_lim) begin
            lo_d      = lo_lim;
            hi_d      = hi_lim;
            nsw_d     = (n_sweeps == '0) ? NSWP_W'(1) : n_sweeps;
            swp_d     = '0;
            core_load = 1'b1;
            up_d      = 1'b1;
            busy_d    = 1'b1;
            err_d     = 1'b0;
            state_d   = UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      UP: begin
        core_en = 1'b1;
        if (count == hi_q) begin
`ifdef SWEEP_DWELL_EN
          core_en = 1'b0;
          dwell_d = DW_W'(DWELL - 1);
          state_d = updn_sweep_pkg::DWELL;
`else
          core_dir = 1'b0;
          up_d     = 1'b0;
          state_d  = DOWN;
`endif
        end
      end
      DOWN: begin
        core_en  = 1'b1;
        core_dir = 1'b0;
        if (count == lo_q) begin
          swp_d = swp_inc;
          if (swp_inc == nsw_q) begin
            core_en = 1'b0;
            up_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FINISH;
          end else begin
`ifdef SWEEP_DWELL_EN
            core_en = 1'b0;
            dwell_d = DW_W'(DWELL - 1);
            state_d = updn_sweep_pkg::DWELL;
`else
            core_dir = 1'b1;
            up_d     = 1'b1;
            state_d  = UP;
`endif
          end
        end
      end
`ifdef SWEEP_DWELL_EN
      // up_q still holds the pre-turnaround direction, so it tells peak from valley
      updn_sweep_pkg::DWELL: begin
        if (dwell_q == '0) begin
          core_en  = 1'b1;
          core_dir = !up_q;
          up_d     = !up_q;
          state_d  = up_q ? DOWN : UP;
        end else begin
          dwell_d = dwell_q - DW_W'(1);
        end
      end
`endif
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort lets the counter finish this edge's step, then freezes it in IDLE.
    if (stop && state_q != IDLE && state_q != FINISH) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      up_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      nsw_q   <= '0;
      swp_q   <= '0;
      up_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SWEEP_DWELL_EN
      dwell_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      nsw_q   <= nsw_d;
      swp_q   <= swp_d;
      up_q    <= up_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef SWEEP_DWELL_EN
      dwell_q <= dwell_d;
`endif
    end
  end

  updn_count_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .en       (core_en),
    .load     (core_load),
    .load_val (core_load_val),
    .up_dwbar (core_dir),
    .count    (count)
  );

  assign up_dwbar = up_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_updn_sweep_ctrl.sv
// Randomized bench for updn_sweep_ctrl against a per-transaction expected trace built from the sweep rules.
module tb_updn_sweep_ctrl;

`ifdef SWEEP_DWELL_EN
  localparam int DW = 3;
`else
  localparam int DW = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] lo_lim = '0;
  logic [7:0] hi_lim = '0;
  logic [3:0] n_sweeps = '0;
  logic [7:0] count;
  logic       up_dwbar, busy, done, err;

  int n_chk = 0;
  int n_err = 0;
  int m_cnt = 0;
  int m_err = 0;
  int q_cnt[$];
  int q_up[$];

  always #5 clk = ~clk;

  updn_sweep_ctrl dut (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start),
    .stop     (stop),
    .lo_lim   (lo_lim),
    .hi_lim   (hi_lim),
    .n_sweeps (n_sweeps),
    .count    (count),
    .up_dwbar (up_dwbar),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_cnt"}, int'(count), m_cnt);
    chk({tag, "_up"}, int'(up_dwbar), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), m_err);
  endtask

  // Expected count/direction for every busy cycle after accept; direction 2 = not checked (dwell).
  task automatic build_trace(input int lo, input int hi, input int n);
    int ne;
    ne = (n == 0) ? 1 : n;
    q_cnt.delete();
    q_up.delete();
    q_cnt.push_back(lo); q_up.push_back(1);
    for (int s = 0; s < ne; s++) begin
      for (int v = lo + 1; v <= hi; v++) begin q_cnt.push_back(v); q_up.push_back(1); end
      for (int d = 0; d < DW; d++) begin q_cnt.push_back(hi); q_up.push_back(2); end
      for (int v = hi - 1; v >= lo; v--) begin q_cnt.push_back(v); q_up.push_back(0); end
      if (s != ne - 1)
        for (int d = 0; d < DW; d++) begin q_cnt.push_back(lo); q_up.push_back(2); end
    end
  endtask

  // stop_sel: -1 none, -2 random, else trace index whose cycle carries stop.
  task automatic run_sweep(input int lo, input int hi, input int n, input int stop_sel);
    int len, stop_at;
    build_trace(lo, hi, n);
    len = q_cnt.size();
    stop_at = stop_sel;
    if (stop_sel == -2)
      stop_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
    lo_lim = 8'(lo); hi_lim = 8'(hi); n_sweeps = 4'(n); start = 1'b1; stop = 1'b0;
    @(negedge clk);
    m_err = 0;
    for (int i = 0; i < len; i++) begin
      chk("cnt", int'(count), q_cnt[i]);
      if (q_up[i] != 2) chk("up", int'(up_dwbar), q_up[i]);
      chk("busy", int'(busy), 1);
      chk("done", int'(done), 0);
      chk("err", int'(err), 0);
      start = 1'($urandom_range(0, 1));
      lo_lim = 8'($urandom); hi_lim = 8'($urandom); n_sweeps = 4'($urandom);
      stop = (i == stop_at);
      @(negedge clk);
      if (i == stop_at) begin
        start = 1'b0; stop = 1'b0;
        m_cnt = (i + 1 < len) ? q_cnt[i + 1] : lo;
        repeat (3) begin
          idle_chk("stop");
          @(negedge clk);
        end
        return;
      end
    end
    chk("fin_cnt", int'(count), lo);
    chk("fin_up", int'(up_dwbar), 1);
    chk("fin_busy", int'(busy), 0);
    chk("fin_done", int'(done), 1);
    start = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
    m_cnt = lo;
    idle_chk("post");
  endtask

  // A start in IDLE that must not launch: bad limits and/or stop raised alongside.
  task automatic try_req(input int lo, input int hi, input logic with_stop);
    lo_lim = 8'(lo); hi_lim = 8'(hi); start = 1'b1; stop = with_stop;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    if (!with_stop && lo >= hi) m_err = 1;
    idle_chk("req");
    @(negedge clk);
    idle_chk("req2");
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1 idle_chk("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_chk("rst_rel");

    run_sweep(3, 6, 2, -1);
    try_req(5, 5, 1'b0);
    run_sweep(0, 2, 1, -1);
    run_sweep(0, 8, 1, 5);
    try_req(1, 9, 1'b1);
    try_req(9, 1, 1'b1);
    run_sweep(1, 3, 1, -1);
    run_sweep(7, 8, 3, -1);
    run_sweep(250, 255, 0, -1);

    lo_lim = 8'd10; hi_lim = 8'd200; n_sweeps = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    m_cnt = 0; m_err = 0;
    idle_chk("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_chk("rst_mid_rel");

    for (int t = 0; t < 30; t++) begin
      int lo, hi;
      lo = int'($urandom_range(0, 235));
      hi = lo + int'($urandom_range(1, 20));
      if ($urandom_range(0, 3) == 0) try_req(hi, lo, 1'b0);
      if ($urandom_range(0, 3) == 0) try_req(lo, hi, 1'b1);
      run_sweep(lo, hi, int'($urandom_range(0, 15)), -2);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
